sipo_deserializer: RTL and testbench

- Serial-in, parallel-out (SIPO) receiver. It assembles N-bit words from a qualified serial bit stream and presents each word on a registered parallel output with a valid/ready handshake.
- It is the receiving end of the serial link whose transmit side is fed by the team's PIPO load registers.
- It contains a shift register, a bit counter, an output holding register and sticky overrun detection.

---
 rtl/sipo_deserializer.sv | 62 ++++++
 tb/tb_sipo_deserializer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles N-bit words from a qualified bit stream.
// Latency: word_out/word_valid update at the edge that captures the last bit of a word.
// Backpressure: a completed word arriving while the previous one is unconsumed is dropped and sets sticky overrun.
module sipo_deserializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          serial_in,
    input  logic          bit_valid,
    output logic [N-1:0]  word_out,
    output logic          word_valid,
    input  logic          word_ready,
    output logic          overrun,
    output logic [CW-1:0] bit_count
);

    logic [N-1:0] shift_q;
    logic [N-1:0] shift_next;
    logic         last_bit;
    logic         consume;
    logic         accept;

    always_comb begin
        if (MSB_FIRST) begin
            shift_next = {shift_q[N-2:0], serial_in};
        end else begin
            shift_next = {serial_in, shift_q[N-1:1]};
        end
        last_bit = bit_valid && (bit_count == CW'(N - 1));
        consume  = word_valid && word_ready;
        // A completing word may be loaded if the holding register is empty or being drained this edge.
        accept   = last_bit && (!word_valid || word_ready);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_q    <= '0;
            bit_count  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (bit_valid) begin
                shift_q   <= shift_next;
                bit_count <= last_bit ? '0 : bit_count + CW'(1);
            end
            if (accept) begin
                word_out   <= shift_next;
                word_valid <= 1'b1;
            end else if (last_bit) begin
                overrun    <= 1'b1;
            end else if (consume) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one stimulus stream
// and are checked against directed expectations and a word-level reference model.
module tb_sipo_deserializer;

    localparam int N  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          serial_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          word_ready = 1'b0;

    logic [N-1:0]  wo_m, wo_l;
    logic          wv_m, wv_l, ov_m, ov_l;
    logic [CW-1:0] bc_m, bc_l;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bit k of a word goes to position N-1-k (MSB-first) or k (LSB-first).
    int           m_cnt;
    logic [N-1:0] m_acc_m, m_acc_l, m_out_m, m_out_l;
    logic         m_vld, m_ovr;

    sipo_deserializer #(.N(N), .MSB_FIRST(1'b1), .CW(CW)) dut_m (
        .clk(clk), .reset(reset), .clear(clear), .serial_in(serial_in), .bit_valid(bit_valid),
        .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready), .overrun(ov_m), .bit_count(bc_m)
    );

    sipo_deserializer #(.N(N), .MSB_FIRST(1'b0), .CW(CW)) dut_l (
        .clk(clk), .reset(reset), .clear(clear), .serial_in(serial_in), .bit_valid(bit_valid),
        .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready), .overrun(ov_l), .bit_count(bc_l)
    );

    always #5 clk = ~clk;

    task automatic step(input logic bv, input logic b, input logic rdy,
                        input logic clr = 1'b0, input logic rst = 1'b0);
        logic done;
        logic cons;
        bit_valid  = bv;
        serial_in  = b;
        word_ready = rdy;
        clear      = clr;
        reset      = rst;
        @(posedge clk);
        if (rst || clr) begin
            m_cnt = 0; m_acc_m = '0; m_acc_l = '0; m_out_m = '0; m_out_l = '0;
            m_vld = 1'b0; m_ovr = 1'b0;
        end else begin
            done = 1'b0;
            cons = m_vld && rdy;
            if (bv) begin
                m_acc_m[N-1-m_cnt] = b;
                m_acc_l[m_cnt]     = b;
                m_cnt++;
                if (m_cnt == N) begin
                    done  = 1'b1;
                    m_cnt = 0;
                end
            end
            if (done && (!m_vld || cons)) begin
                m_out_m = m_acc_m; m_out_l = m_acc_l; m_vld = 1'b1;
            end else if (done) begin
                m_ovr = 1'b1;
            end else if (cons) begin
                m_vld = 1'b0;
            end
        end
        #1;
    endtask

    // Sends s[N-1] first; MSB-first instance should see s, LSB-first sees s bit-reversed.
    task automatic send_stream(input logic [N-1:0] s, input logic rdy);
        for (int i = 0; i < N; i++) step(1'b1, s[N-1-i], rdy);
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if ({wo_m, wv_m, ov_m, bc_m} !== '0) begin
            n_err++; $display("FAIL reset_msb got out=%h vld=%b ovr=%b cnt=%0d want all zero", wo_m, wv_m, ov_m, bc_m);
        end
        n_vec++;
        if ({wo_l, wv_l, ov_l, bc_l} !== '0) begin
            n_err++; $display("FAIL reset_lsb got out=%h vld=%b ovr=%b cnt=%0d want all zero", wo_l, wv_l, ov_l, bc_l);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_msb_basic;
        logic [N-1:0] s;
        s = 8'hA5;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            step(1'b1, s[N-1-i], 1'b1);
            n_vec++;
            if (bc_m !== CW'((i + 1) % N)) begin
                n_err++; $display("FAIL msb_bit_count bit %0d got %0d want %0d", i, bc_m, (i + 1) % N);
            end
        end
        n_vec++;
        if (wv_m !== 1'b1 || wo_m !== 8'hA5) begin
            n_err++; $display("FAIL msb_word got vld=%b out=%h want vld=1 out=a5", wv_m, wo_m);
        end
        step(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (wv_m !== 1'b0 || wo_m !== 8'hA5) begin
            n_err++; $display("FAIL msb_consume got vld=%b out=%h want vld=0 out=a5", wv_m, wo_m);
        end
    endtask

    task automatic test_lsb_basic;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_stream(8'hA5, 1'b1);
        n_vec++;
        if (wv_l !== 1'b1 || wo_l !== 8'hA5) begin
            n_err++; $display("FAIL lsb_palindrome got vld=%b out=%h want vld=1 out=a5", wv_l, wo_l);
        end
        send_stream(8'h80, 1'b1);
        n_vec++;
        if (wo_l !== 8'h01 || wv_l !== 1'b1) begin
            n_err++; $display("FAIL lsb_word01 got vld=%b out=%h want vld=1 out=01", wv_l, wo_l);
        end
        n_vec++;
        if (wo_m !== 8'h80) begin
            n_err++; $display("FAIL msb_word80 got %h want 80", wo_m);
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overrun;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_stream(8'h3C, 1'b0);
        n_vec++;
        if (wv_m !== 1'b1 || wo_m !== 8'h3C || ov_m !== 1'b0) begin
            n_err++; $display("FAIL ovr_first got vld=%b out=%h ovr=%b want 1 3c 0", wv_m, wo_m, ov_m);
        end
        send_stream(8'hC3, 1'b0);
        n_vec++;
        if (wv_m !== 1'b1 || wo_m !== 8'h3C || ov_m !== 1'b1) begin
            n_err++; $display("FAIL ovr_drop_msb got vld=%b out=%h ovr=%b want 1 3c 1", wv_m, wo_m, ov_m);
        end
        n_vec++;
        if (wo_l !== 8'h3C || ov_l !== 1'b1) begin
            n_err++; $display("FAIL ovr_drop_lsb got out=%h ovr=%b want 3c 1", wo_l, ov_l);
        end
        step(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (wv_m !== 1'b0 || ov_m !== 1'b1 || wo_m !== 8'h3C) begin
            n_err++; $display("FAIL ovr_sticky got vld=%b ovr=%b out=%h want 0 1 3c", wv_m, ov_m, wo_m);
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] s;
        s = 8'h22;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_stream(8'h11, 1'b0);
        n_vec++;
        if (wv_m !== 1'b1 || wo_m !== 8'h11) begin
            n_err++; $display("FAIL b2b_first got vld=%b out=%h want 1 11", wv_m, wo_m);
        end
        for (int i = 0; i < N; i++) begin
            step(1'b1, s[N-1-i], (i == N - 1));
            n_vec++;
            if (wv_m !== 1'b1) begin
                n_err++; $display("FAIL b2b_valid_gap bit %0d got vld=%b want 1", i, wv_m);
            end
        end
        n_vec++;
        if (wo_m !== 8'h22 || ov_m !== 1'b0) begin
            n_err++; $display("FAIL b2b_second got out=%h ovr=%b want 22 0", wo_m, ov_m);
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_gaps;
        logic [N-1:0] s;
        int gap;
        s = 8'h5A;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            gap = $urandom_range(1, 5);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'($urandom), 1'b1);
                n_vec++;
                if (bc_m !== CW'(i) || bc_l !== CW'(i)) begin
                    n_err++; $display("FAIL gap_hold bit %0d got %0d/%0d want %0d", i, bc_m, bc_l, i);
                end
            end
            step(1'b1, s[N-1-i], 1'b1);
        end
        n_vec++;
        if (wv_m !== 1'b1 || wo_m !== 8'h5A || wo_m !== m_out_m) begin
            n_err++; $display("FAIL gap_word got vld=%b out=%h want 1 5a", wv_m, wo_m);
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear_mid(input logic use_reset);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_stream(8'h0F, 1'b0);
        send_stream(8'hF0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom), 1'b0);
        n_vec++;
        if (bc_m !== CW'(4) || ov_m !== 1'b1) begin
            n_err++; $display("FAIL clr_setup got cnt=%0d ovr=%b want 4 1", bc_m, ov_m);
        end
        step(1'b0, 1'b0, 1'b0, !use_reset, use_reset);
        n_vec++;
        if (bc_m !== '0 || wv_m !== 1'b0 || ov_m !== 1'b0 || bc_l !== '0 || ov_l !== 1'b0) begin
            n_err++; $display("FAIL clr_state rst=%b got cnt=%0d vld=%b ovr=%b want 0 0 0", use_reset, bc_m, wv_m, ov_m);
        end
        send_stream(8'hFF, 1'b1);
        n_vec++;
        if (wv_m !== 1'b1 || wo_m !== 8'hFF || wo_l !== 8'hFF) begin
            n_err++; $display("FAIL clr_next_word rst=%b got vld=%b out=%h/%h want 1 ff", use_reset, wv_m, wo_m, wo_l);
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0));
            n_vec++;
            if ({wo_m, wv_m, ov_m, bc_m} !== {m_out_m, m_vld, m_ovr, CW'(m_cnt)}) begin
                n_err++; $display("FAIL rand_msb cycle %0d got %h %b %b %0d want %h %b %b %0d",
                                  c, wo_m, wv_m, ov_m, bc_m, m_out_m, m_vld, m_ovr, m_cnt);
            end
            n_vec++;
            if ({wo_l, wv_l, ov_l, bc_l} !== {m_out_l, m_vld, m_ovr, CW'(m_cnt)}) begin
                n_err++; $display("FAIL rand_lsb cycle %0d got %h %b %b %0d want %h %b %b %0d",
                                  c, wo_l, wv_l, ov_l, bc_l, m_out_l, m_vld, m_ovr, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_basic();
        test_lsb_basic();
        test_overrun();
        test_back_to_back();
        test_gaps();
        test_clear_mid(1'b0);
        test_clear_mid(1'b1);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
